// File: rtl/hazard_unit.sv
// hazard_unit: MIPS 5-stage stall/flush/forward control with HI/LO busy tracking and a stall counter
module hazard_unit #(
  parameter int MD_CYCLES = 4,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rsd,
  input  logic [4:0]       rtd,
  input  logic             branchd,
  input  logic             jr_d,
  input  logic             hilo_wed,
  input  logic             mfhilo_d,
  input  logic [4:0]       rse,
  input  logic [4:0]       rte,
  input  logic [4:0]       rf_wae,
  input  logic             we_rege,
  input  logic [1:0]       dm2rege,
  input  logic             hilo_wee,
  input  logic [4:0]       rf_wam,
  input  logic             we_regm,
  input  logic [1:0]       dm2regm,
  input  logic [4:0]       rf_waw,
  input  logic             we_regw,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_e,
  output logic             forward_ad,
  output logic             forward_bd,
  output logic [1:0]       forward_ae,
  output logic [1:0]       forward_be,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_count
);
  localparam int MW = $clog2(MD_CYCLES + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t        state;
  logic [MW-1:0] md_cnt;
  logic          m_rs_e, m_rt_e, w_rs_e, w_rt_e;
  logic          hit_rs, hit_rt, lu, br, md, stall;
  assign m_rs_e = we_regm && rf_wam != 5'd0 && rf_wam == rse;
  assign m_rt_e = we_regm && rf_wam != 5'd0 && rf_wam == rte;
  assign w_rs_e = we_regw && rf_waw != 5'd0 && rf_waw == rse;
  assign w_rt_e = we_regw && rf_waw != 5'd0 && rf_waw == rte;
  // a branch/jr operand is unavailable if E is producing it or M holds a load of it
  assign hit_rs = rsd != 5'd0 && ((we_rege && rf_wae == rsd) || (we_regm && dm2regm == 2'b01 && rf_wam == rsd));
  assign hit_rt = rtd != 5'd0 && ((we_rege && rf_wae == rtd) || (we_regm && dm2regm == 2'b01 && rf_wam == rtd));
  assign lu = we_rege && dm2rege == 2'b01 && rf_wae != 5'd0 && (rf_wae == rsd || rf_wae == rtd);
  assign br = (branchd && (hit_rs || hit_rt)) || (jr_d && hit_rs);
  assign md = md_busy && (mfhilo_d || hilo_wed);
  assign stall = !rst && (lu || br || md);
  assign md_busy = state == BUSY;
  // forwarding selects and stall controls, all held low during reset
  always_comb begin
    stall_f    = stall;
    stall_d    = stall;
    flush_e    = stall;
    forward_ae = rst ? 2'b00 : m_rs_e ? 2'b10 : w_rs_e ? 2'b01 : 2'b00;
    forward_be = rst ? 2'b00 : m_rt_e ? 2'b10 : w_rt_e ? 2'b01 : 2'b00;
    forward_ad = !rst && we_regm && rf_wam != 5'd0 && rf_wam == rsd && dm2regm != 2'b01;
    forward_bd = !rst && we_regm && rf_wam != 5'd0 && rf_wam == rtd && dm2regm != 2'b01;
  end
  // HI/LO occupancy: a new HI/LO write always restarts the busy window
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      md_cnt <= '0;
    end else if (hilo_wee) begin
      state  <= BUSY;
      md_cnt <= MW'(MD_CYCLES);
    end else if (state == BUSY) begin
      state  <= md_cnt == MW'(1) ? IDLE : BUSY;
      md_cnt <= md_cnt == MW'(1) ? '0 : md_cnt - MW'(1);
    end
  end
  // saturating count of stalled decode cycles
  always_ff @(posedge clk) begin
    if (rst) stall_count <= '0;
    else if (stall_d && !(&stall_count)) stall_count <= stall_count + CNT_W'(1);
  end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed checks of forwarding, stalls, HI/LO busy window and stall counter
module tb_hazard_unit;
  logic       clk = 0, rst;
  logic [4:0] rsd, rtd, rse, rte, rf_wae, rf_wam, rf_waw;
  logic       branchd, jr_d, hilo_wed, mfhilo_d, we_rege, hilo_wee, we_regm, we_regw;
  logic [1:0] dm2rege, dm2regm;
  logic       stall_f, stall_d, flush_e, forward_ad, forward_bd, md_busy;
  logic [1:0] forward_ae, forward_be;
  logic [3:0] stall_count;
  int total = 0, bad = 0;

  hazard_unit #(.MD_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .rsd(rsd), .rtd(rtd), .branchd(branchd), .jr_d(jr_d),
    .hilo_wed(hilo_wed), .mfhilo_d(mfhilo_d), .rse(rse), .rte(rte), .rf_wae(rf_wae),
    .we_rege(we_rege), .dm2rege(dm2rege), .hilo_wee(hilo_wee), .rf_wam(rf_wam),
    .we_regm(we_regm), .dm2regm(dm2regm), .rf_waw(rf_waw), .we_regw(we_regw),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e), .forward_ad(forward_ad),
    .forward_bd(forward_bd), .forward_ae(forward_ae), .forward_be(forward_be),
    .md_busy(md_busy), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    {rsd, rtd, rse, rte, rf_wae, rf_wam, rf_waw} = '0;
    {branchd, jr_d, hilo_wed, mfhilo_d, we_rege, hilo_wee, we_regm, we_regw} = '0;
    dm2rege = 2'b00;
    dm2regm = 2'b00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lu();
    we_rege = 1; dm2rege = 2'b01; rf_wae = 5'd8; rsd = 5'd8;
  endtask

  initial begin
    rst = 1;
    clr();
    tick(); tick();
    chk("rst_count", 32'(stall_count), 0);
    chk("rst_busy", 32'(md_busy), 0);
    set_lu(); rse = 5; we_regm = 1; rf_wam = 5;
    #1;
    chk("rst_stall_forced", 32'({stall_f, stall_d, flush_e}), 0);
    chk("rst_fwd_forced", 32'(forward_ae), 0);
    clr();
    rst = 0;
    // forwarding priority
    rse = 5; we_regm = 1; rf_wam = 5; we_regw = 1; rf_waw = 5;
    #1 chk("fae_m_prio", 32'(forward_ae), 2);
    we_regm = 0;
    #1 chk("fae_w", 32'(forward_ae), 1);
    rte = 5;
    #1 chk("fbe_w", 32'(forward_be), 1);
    rse = 0; rte = 0; rf_wam = 0; we_regm = 1; rf_waw = 0;
    #1 chk("fae_r0", 32'(forward_ae), 0);
    chk("r0_nostall", 32'(stall_d), 0);
    clr();
    // load-use
    set_lu();
    #1 chk("lu_stall", 32'({stall_f, stall_d, flush_e}), 7);
    tick();
    chk("lu_count", 32'(stall_count), 1);
    clr(); rsd = 8; we_regm = 1; dm2regm = 2'b01; rf_wam = 8;
    #1 chk("lu_release", 32'(stall_d), 0);
    chk("fad_load_m", 32'(forward_ad), 0);
    clr(); we_rege = 1; dm2rege = 2'b01; rf_wae = 0; rsd = 0;
    #1 chk("lu_r0", 32'(stall_d), 0);
    tick();
    chk("lu_r0_count", 32'(stall_count), 1);
    // beq dependent on E ALU result, then on M
    clr(); branchd = 1; rsd = 3; rtd = 4; we_rege = 1; rf_wae = 3;
    #1 chk("br_stall", 32'({stall_f, stall_d, flush_e}), 7);
    tick();
    chk("br_count", 32'(stall_count), 2);
    we_rege = 0; rf_wae = 0; we_regm = 1; rf_wam = 3;
    #1 chk("br_fad", 32'(forward_ad), 1);
    chk("br_fbd", 32'(forward_bd), 0);
    chk("br_nostall", 32'(stall_d), 0);
    // jr waiting on a load in M
    clr(); jr_d = 1; rsd = 7; we_regm = 1; dm2regm = 2'b01; rf_wam = 7;
    #1 chk("jr_stall", 32'(stall_d), 1);
    tick();
    chk("jr_count", 32'(stall_count), 3);
    // HI/LO busy window
    clr(); hilo_wee = 1; mfhilo_d = 1;
    #1 chk("md_pre_busy", 32'(md_busy), 0);
    chk("md_pre_stall", 32'(stall_d), 0);
    tick();
    hilo_wee = 0;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("md_busy%0d", i), 32'(md_busy), 1);
      chk($sformatf("md_stall%0d", i), 32'(stall_d), 1);
      tick();
    end
    chk("md_done_busy", 32'(md_busy), 0);
    chk("md_done_stall", 32'(stall_d), 0);
    chk("md_count", 32'(stall_count), 7);
    // load-use and HI/LO stall together count once
    mfhilo_d = 0; hilo_wee = 1;
    tick();
    hilo_wee = 0; mfhilo_d = 1; set_lu();
    #1 chk("both_stall", 32'(stall_d), 1);
    tick();
    chk("both_count", 32'(stall_count), 8);
    clr();
    tick(); tick(); tick();
    chk("both_idle", 32'(md_busy), 0);
    chk("both_count2", 32'(stall_count), 8);
    // saturation
    set_lu();
    repeat (16) tick();
    chk("sat", 32'(stall_count), 15);
    tick();
    chk("sat_hold", 32'(stall_count), 15);
    // reset during BUSY
    clr(); hilo_wee = 1;
    tick();
    hilo_wee = 0;
    chk("pre_rst_busy", 32'(md_busy), 1);
    rst = 1;
    tick();
    chk("rst_mid_busy", 32'(md_busy), 0);
    chk("rst_mid_count", 32'(stall_count), 0);
    rst = 0;
    tick();
    chk("rst_stays_idle", 32'(md_busy), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
